// File: rtl/pll_reconfig_writer.sv
// Avalon-MM master that loads N/M/C0/C1/K into the PLL reconfig slave, starts
// the update, then waits for relock and reports done or a lock timeout.
module pll_reconfig_writer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 1000000
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c0,
  input  logic [17:0] cfg_c1,
  input  logic [31:0] cfg_k,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_C1, S_WR_K, S_START,
    S_SETTLE, S_WAIT_LOCK, S_DONE, S_ERR
  } state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [19:0] LOCK_LAST   = 20'(LOCK_TIMEOUT - 1);

  state_t      state, next_wr;
  logic [17:0] n_q, m_q, c0_q, c1_q;
  logic [31:0] k_q;
  logic [7:0]  settle_cnt;
  logic [19:0] lock_cnt;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;

  // Address/data of the write owned by the current state, and the state that follows it
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    next_wr = S_IDLE;
    case (state)
      S_MODE:  begin wr_addr = 6'd0; wr_data = 32'd0;                     next_wr = S_WR_N;   end
      S_WR_N:  begin wr_addr = 6'd3; wr_data = {14'b0, n_q};              next_wr = S_WR_M;   end
      S_WR_M:  begin wr_addr = 6'd4; wr_data = {14'b0, m_q};              next_wr = S_WR_C0;  end
      S_WR_C0: begin wr_addr = 6'd5; wr_data = {9'b0, 5'd0, c0_q};        next_wr = S_WR_C1;  end
      S_WR_C1: begin wr_addr = 6'd5; wr_data = {9'b0, 5'd1, c1_q};        next_wr = S_WR_K;   end
      S_WR_K:  begin wr_addr = 6'd7; wr_data = k_q;                       next_wr = S_START;  end
      S_START: begin wr_addr = 6'd2; wr_data = 32'd1;                     next_wr = S_SETTLE; end
      default: ;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state          <= S_IDLE;
      mgmt_address   <= '0;
      mgmt_write     <= 1'b0;
      mgmt_writedata <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout_err    <= 1'b0;
      settle_cnt     <= '0;
      lock_cnt       <= '0;
      n_q            <= '0;
      m_q            <= '0;
      c0_q           <= '0;
      c1_q           <= '0;
      k_q            <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_req) begin
            n_q         <= cfg_n;
            m_q         <= cfg_m;
            c0_q        <= cfg_c0;
            c1_q        <= cfg_c1;
            k_q         <= cfg_k;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            state       <= S_MODE;
          end
        end
        S_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_C1, S_WR_K, S_START: begin
          // Idle cycle presents the write; it then holds until the slave accepts it
          if (!mgmt_write) begin
            mgmt_write     <= 1'b1;
            mgmt_address   <= wr_addr;
            mgmt_writedata <= wr_data;
          end else if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            settle_cnt <= '0;
            state      <= next_wr;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            lock_cnt <= '0;
            state    <= S_WAIT_LOCK;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        S_WAIT_LOCK: begin
          // Lock is checked first so a same-cycle lock beats the timeout
          if (pll_locked) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (lock_cnt == LOCK_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_ERR;
          end else begin
            lock_cnt <= lock_cnt + 20'd1;
          end
        end
        S_DONE, S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_writer.sv
// Directed bench for pll_reconfig_writer: write sequence, stall, timeout,
// ignored request, mid-sequence reset and lock/timeout tie.
module tb_pll_reconfig_writer;

  logic        refclk = 1'b0;
  logic        rst, cfg_req, pll_locked, mgmt_waitrequest;
  logic [17:0] cfg_n, cfg_m, cfg_c0, cfg_c1;
  logic [31:0] cfg_k;
  logic [5:0]  mgmt_address;
  logic        mgmt_write, busy, done, timeout_err;
  logic [31:0] mgmt_writedata;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int d0;
  logic [37:0] wq[$];
  logic [37:0] exp_w[7];

  pll_reconfig_writer #(.SETTLE_CYCLES(16), .LOCK_TIMEOUT(100)) dut (
    .refclk(refclk), .rst(rst), .cfg_req(cfg_req),
    .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c0(cfg_c0), .cfg_c1(cfg_c1), .cfg_k(cfg_k),
    .pll_locked(pll_locked), .mgmt_waitrequest(mgmt_waitrequest),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #10 refclk = ~refclk;

  // Log accepted writes and done pulses mid-cycle
  always @(negedge refclk) begin
    if (!rst && mgmt_write && !mgmt_waitrequest) wq.push_back({mgmt_address, mgmt_writedata});
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [17:0] n, m, c0, c1, input logic [31:0] k);
    cfg_n = n; cfg_m = m; cfg_c0 = c0; cfg_c1 = c1; cfg_k = k;
    cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
  endtask

  task automatic wait_wr(input logic [5:0] a, input int maxc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < maxc && !found; i++) begin
      tick();
      if (mgmt_write && mgmt_address == a) found = 1'b1;
    end
    chk($sformatf("wait_wr_addr%0d", a), 64'(found), 64'd1);
  endtask

  task automatic wait_done(input int maxc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < maxc && !found; i++) begin
      tick();
      if (done) found = 1'b1;
    end
    chk("wait_done", 64'(found), 64'd1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, 64'(wq.size()), 64'd7);
    for (int i = 0; i < 7 && i < wq.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 64'(wq[i]), 64'(exp_w[i]));
  endtask

  task automatic set_nominal();
    exp_w[0] = {6'd0, 32'h0};
    exp_w[1] = {6'd3, 32'h0001_0000};
    exp_w[2] = {6'd4, 32'h0000_0404};
    exp_w[3] = {6'd5, 32'h0000_0202};
    exp_w[4] = {6'd5, 32'h0004_0404};
    exp_w[5] = {6'd7, 32'h9BA5_E354};
    exp_w[6] = {6'd2, 32'h1};
  endtask

  initial begin
    rst = 1'b1; cfg_req = 1'b0; pll_locked = 1'b1; mgmt_waitrequest = 1'b0;
    cfg_n = '0; cfg_m = '0; cfg_c0 = '0; cfg_c1 = '0; cfg_k = '0;
    repeat (3) tick();
    chk("rst_addr", 64'(mgmt_address), 64'd0);
    chk("rst_write", 64'(mgmt_write), 64'd0);
    chk("rst_data", 64'(mgmt_writedata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);
    rst = 1'b0;
    tick();

    // Nominal sequence
    set_nominal();
    wq.delete();
    d0 = done_cnt;
    send(18'h10000, 18'h00404, 18'h00202, 18'h00404, 32'h9BA5E354);
    chk("lat_edge1_write", 64'(mgmt_write), 64'd0);
    chk("lat_edge1_busy", 64'(busy), 64'd1);
    tick();
    chk("lat_edge2_write", 64'(mgmt_write), 64'd1);
    chk("lat_edge2_addr", 64'(mgmt_address), 64'd0);
    pll_locked = 1'b0;
    wait_wr(6'd2, 40);
    repeat (40) tick();
    pll_locked = 1'b1;
    wait_done(50);
    tick();
    chk("nom_done_drop", 64'(done), 64'd0);
    chk("nom_busy_low", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("nom_done_once", 64'(done_cnt - d0), 64'd1);
    check_writes("nom");

    // Waitrequest stall on WR_M
    wq.delete();
    send(18'h10000, 18'h00404, 18'h00202, 18'h00404, 32'h9BA5E354);
    wait_wr(6'd4, 20);
    mgmt_waitrequest = 1'b1;
    chk("stall0", 64'({mgmt_write, mgmt_address, mgmt_writedata}), 64'({1'b1, 6'd4, 32'h404}));
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("stall%0d", i), 64'({mgmt_write, mgmt_address, mgmt_writedata}),
          64'({1'b1, 6'd4, 32'h404}));
    end
    mgmt_waitrequest = 1'b0;
    wait_done(60);
    tick();
    check_writes("stall");

    // Lock timeout
    wq.delete();
    pll_locked = 1'b0;
    d0 = done_cnt;
    send(18'h10000, 18'h00404, 18'h00202, 18'h00404, 32'h9BA5E354);
    wait_wr(6'd2, 20);
    tick();
    repeat (115) tick();
    chk("to_terr_early", 64'(timeout_err), 64'd0);
    chk("to_busy_early", 64'(busy), 64'd1);
    tick();
    chk("to_terr_set", 64'(timeout_err), 64'd1);
    chk("to_no_done", 64'(done), 64'd0);
    tick();
    chk("to_busy_low", 64'(busy), 64'd0);
    repeat (5) tick();
    chk("to_terr_sticky", 64'(timeout_err), 64'd1);
    chk("to_done_cnt", 64'(done_cnt - d0), 64'd0);

    // Request while busy is ignored
    exp_w[0] = {6'd0, 32'h0};
    exp_w[1] = {6'd3, 32'h1};
    exp_w[2] = {6'd4, 32'h2};
    exp_w[3] = {6'd5, 32'h3};
    exp_w[4] = {6'd5, 32'h0004_0004};
    exp_w[5] = {6'd7, 32'h1122_3344};
    exp_w[6] = {6'd2, 32'h1};
    wq.delete();
    pll_locked = 1'b1;
    send(18'h1, 18'h2, 18'h3, 18'h4, 32'h11223344);
    chk("req_clears_terr", 64'(timeout_err), 64'd0);
    wait_wr(6'd5, 20);
    send(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 32'hFFFFFFFF);
    wait_done(60);
    tick();
    check_writes("ignore");

    // Reset during a stalled WR_K
    set_nominal();
    wq.delete();
    send(18'h10000, 18'h00404, 18'h00202, 18'h00404, 32'h9BA5E354);
    wait_wr(6'd7, 30);
    mgmt_waitrequest = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("mrst_outs", 64'({mgmt_address, mgmt_write, mgmt_writedata, busy, done, timeout_err}), 64'd0);
    rst = 1'b0;
    mgmt_waitrequest = 1'b0;
    repeat (3) tick();
    chk("mrst_no_retry", 64'({mgmt_write, busy}), 64'd0);
    chk("mrst_partial", 64'(wq.size()), 64'd5);
    wq.delete();
    send(18'h10000, 18'h00404, 18'h00202, 18'h00404, 32'h9BA5E354);
    chk("mrst_restart_e1", 64'(mgmt_write), 64'd0);
    tick();
    chk("mrst_restart_e2", 64'({mgmt_write, mgmt_address}), 64'({1'b1, 6'd0}));
    wait_done(60);
    tick();
    check_writes("mrst");

    // Lock arrives on the timeout cycle
    pll_locked = 1'b0;
    send(18'h10000, 18'h00404, 18'h00202, 18'h00404, 32'h9BA5E354);
    wait_wr(6'd2, 20);
    tick();
    repeat (115) tick();
    pll_locked = 1'b1;
    tick();
    chk("tie_done", 64'(done), 64'd1);
    chk("tie_terr", 64'(timeout_err), 64'd0);
    tick();
    chk("tie_busy_low", 64'(busy), 64'd0);
    chk("tie_terr_after", 64'(timeout_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
